gate_response_checker: RTL and testbench
========================================

# gate_response_checker

Synthesizable self-checking exerciser for the two-input basic logic gates. It drives the four input vectors 00, 01, 10, 11 into a gate under test. After a settle interval it samples the gate output and compares it with the expected truth table for a selected gate type. It then reports per-vector mismatches, an error count and pass/fail, and sits beside any gate module in place of a hand-written stimulus bench.

## Interface
- SETTLE_CYCLES, 2, extra cycles each vector is held before sampling; legal 0..15
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  run request; sampled only in IDLE
- gate_sel  input  3  gate type, latched on accepted start: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(a), 7 BUF(a)
- y  input  1  output of gate under test
- a  output  1  gate input a (registered)
- b  output  1  gate input b (registered)
- busy  output  1  run in progress
- done  output  1  one-cycle pulse after final sample
- pass  output  1  last run had zero mismatches
- err_count  output  3  mismatch count of last run, 0..4
- fail_vec  output  4  bit k set if vector k = {a,b} mismatched

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on start=1:
  - latch gate_sel
  - a,b ← 0,0
  - vector index ← 0, hold counter ← 0
  - clear pass, err_count, fail_vec
- RUN, each edge:
  - If hold counter ≠ SETTLE_CYCLES: increment the counter.
  - Else, sample step:
    - compare y against exp[idx]
    - on mismatch, set fail_vec[idx] and increment err_count
    - counter ← 0
  - After a sample step with idx<3: idx++ and {a,b} ← idx+1.
  - After a sample step with idx=3: {a,b} ← 00; pass ← (no mismatch including this sample); go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Expected truth constants, bit k for {a,b}=k:
  - AND 1000, OR 1110, NAND 0111, NOR 0001
  - XOR 0110, XNOR 1001, NOT 0011, BUF 1100
- start is ignored in RUN and DONE, with no queuing. start held high in IDLE launches a new run each time IDLE is reached.
- gate_sel changes during a run have no effect.
- Results hold until the next accepted start or reset.

## Timing
- Reset values:
  - state IDLE; a=0, b=0
  - busy=0, done=0, pass=0, err_count=0, fail_vec=0000
  - internal idx and counter 0
- Reset is asynchronous and takes effect mid-run: the run is abandoned and no done is produced.
- Take the accepting edge as E0. With H = SETTLE_CYCLES+1:
  - each vector is visible on a,b for exactly H cycles, starting after E0
  - y is sampled at edges E0+H·(k+1), k=0..3
  - busy=1 from after E0 through the final sample edge E0+4H
  - done=1 in the cycle after E0+4H
  - IDLE is reached after edge E0+4H+1
  - the earliest next accepted start is at edge E0+4H+1
- pass, err_count and fail_vec are final when done is high.
- The DUT path y must settle within H cycles. The checker samples y directly, with no synchronizer.

## Structure
- Package gate_check_pkg holds:
  - gate_sel encoding constants (GATE_AND..GATE_BUF)
  - 4-bit expected truth-table constants
  - state encoding
- Sub-module gate_truth_rom: combinational gate_sel[2:0], idx[1:0] → expected bit, reading the package constants.
- Top holds the FSM, hold counter, vector index and result registers.

## Test plan
- SETTLE_CYCLES=2, gate_sel=0, y=a&b from a real AND gate, start pulse at E0:
  - a,b = 00,01,10,11 with each held 3 cycles
  - done at the cycle after E0+12
  - pass=1, err_count=0, fail_vec=0000
- gate_sel=0, y stuck at 0 → pass=0, err_count=1, fail_vec=1000.
- gate_sel=3 (NOR), y stuck at 1 → err_count=3, fail_vec=1110; then gate_sel=4 with a correct XOR → pass=1, with previous results cleared at start.
- SETTLE_CYCLES=0, gate_sel=7, y=a → samples at E0+1..E0+4, done after E0+4, pass=1; start held high launches a second run at E0+5.
- start pulsed while busy → no restart, timing unchanged. rst asserted at E0+5 → outputs go to reset values immediately, done never pulses, and the next start begins again at vector 00.

Source files
------------

// File: rtl/gate_check_pkg.sv
// Shared encodings for the gate response checker: gate selectors,
// expected truth tables (bit k is the output for {a,b}=k) and FSM states.
package gate_check_pkg;

   localparam logic [2:0] GATE_AND  = 3'd0;
   localparam logic [2:0] GATE_OR   = 3'd1;
   localparam logic [2:0] GATE_NAND = 3'd2;
   localparam logic [2:0] GATE_NOR  = 3'd3;
   localparam logic [2:0] GATE_XOR  = 3'd4;
   localparam logic [2:0] GATE_XNOR = 3'd5;
   localparam logic [2:0] GATE_NOT  = 3'd6;
   localparam logic [2:0] GATE_BUF  = 3'd7;

   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;
   localparam logic [3:0] TT_NOT  = 4'b0011;
   localparam logic [3:0] TT_BUF  = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic [3:0] truth_table(input logic [2:0] sel);
      logic [3:0] tt;
      case (sel)
         GATE_AND:  tt = TT_AND;
         GATE_OR:   tt = TT_OR;
         GATE_NAND: tt = TT_NAND;
         GATE_NOR:  tt = TT_NOR;
         GATE_XOR:  tt = TT_XOR;
         GATE_XNOR: tt = TT_XNOR;
         GATE_NOT:  tt = TT_NOT;
         default:   tt = TT_BUF;
      endcase
      return tt;
   endfunction

endpackage

// File: rtl/gate_truth_rom.sv
// Expected gate output for a given gate type and input vector index.
module gate_truth_rom
   import gate_check_pkg::*;
(
   input  logic [2:0] gate_sel,
   input  logic [1:0] idx,
   output logic       exp_bit
);

   logic [3:0] tt;

   always_comb begin
      tt      = truth_table(gate_sel);
      exp_bit = tt[idx];
   end

endmodule

// File: rtl/gate_response_checker.sv
// Drives the four {a,b} vectors into a gate under test, samples y after a
// settle interval and reports per-vector mismatches, an error count and pass.
module gate_response_checker
   import gate_check_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] gate_sel,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] fail_vec
);

   localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

   state_e     state_q;
   logic [2:0] sel_q;
   logic [1:0] idx_q;
   logic [3:0] cnt_q;
   logic       a_q, b_q, busy_q, done_q, pass_q;
   logic [2:0] err_q;
   logic [3:0] fail_q;

   logic       exp_bit;
   logic       mismatch;
   logic [2:0] err_d;
   logic [3:0] fail_d;

   gate_truth_rom u_rom (
      .gate_sel (sel_q),
      .idx      (idx_q),
      .exp_bit  (exp_bit)
   );

   always_comb begin
      mismatch       = (y != exp_bit);
      err_d          = err_q + {2'b00, mismatch};
      fail_d         = fail_q;
      fail_d[idx_q]  = fail_q[idx_q] | mismatch;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fail_q  <= '0;
      end else begin
         case (state_q)
            // DONE falls back to IDLE on the same edge a held start is
            // accepted, so a back-to-back run launches at E0+4H+1.
            ST_IDLE, ST_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= ST_RUN;
                  sel_q   <= gate_sel;
                  idx_q   <= '0;
                  cnt_q   <= '0;
                  a_q     <= 1'b0;
                  b_q     <= 1'b0;
                  busy_q  <= 1'b1;
                  pass_q  <= 1'b0;
                  err_q   <= '0;
                  fail_q  <= '0;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (cnt_q != SETTLE) begin
                  cnt_q <= cnt_q + 4'd1;
               end else begin
                  cnt_q  <= '0;
                  err_q  <= err_d;
                  fail_q <= fail_d;
                  if (idx_q != 2'd3) begin
                     idx_q      <= idx_q + 2'd1;
                     {a_q, b_q} <= idx_q + 2'd1;
                  end else begin
                     idx_q   <= '0;
                     a_q     <= 1'b0;
                     b_q     <= 1'b0;
                     pass_q  <= (err_d == 3'd0);
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign a         = a_q;
   assign b         = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Randomized bench for gate_response_checker with two instances
// (SETTLE_CYCLES 2 and 0) against a truth-table reference model.
module tb_gate_response_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_s [2];
   logic [2:0] sel_s   [2];
   logic       y_s     [2];
   logic       a_s     [2];
   logic       b_s     [2];
   logic       busy_s  [2];
   logic       done_s  [2];
   logic       pass_s  [2];
   logic [2:0] err_s   [2];
   logic [3:0] fail_s  [2];
   logic [3:0] ytab    [2];

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   // The gate under test is a lookup of {a,b} into a bench-chosen table.
   assign y_s[0] = ytab[0][{a_s[0], b_s[0]}];
   assign y_s[1] = ytab[1][{a_s[1], b_s[1]}];

   gate_response_checker #(.SETTLE_CYCLES(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start_s[0]), .gate_sel(sel_s[0]), .y(y_s[0]),
      .a(a_s[0]), .b(b_s[0]), .busy(busy_s[0]), .done(done_s[0]),
      .pass(pass_s[0]), .err_count(err_s[0]), .fail_vec(fail_s[0])
   );

   gate_response_checker #(.SETTLE_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start_s[1]), .gate_sel(sel_s[1]), .y(y_s[1]),
      .a(a_s[1]), .b(b_s[1]), .busy(busy_s[1]), .done(done_s[1]),
      .pass(pass_s[1]), .err_count(err_s[1]), .fail_vec(fail_s[1])
   );

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] model_tt(input int unsigned sel);
      logic [3:0] tt;
      for (int k = 0; k < 4; k++) begin
         bit av, bv;
         av = (k / 2) % 2;
         bv = k % 2;
         case (sel)
            0: tt[k] = av & bv;
            1: tt[k] = av | bv;
            2: tt[k] = !(av & bv);
            3: tt[k] = !(av | bv);
            4: tt[k] = av ^ bv;
            5: tt[k] = !(av ^ bv);
            6: tt[k] = !av;
            default: tt[k] = av;
         endcase
      end
      return tt;
   endfunction

   function automatic int unsigned popcount4(input logic [3:0] v);
      int unsigned n = 0;
      for (int k = 0; k < 4; k++) n += v[k];
      return n;
   endfunction

   function automatic int unsigned hold_of(input int d);
      return (d == 0) ? 3 : 1;
   endfunction

   task automatic check_reset_values(input int d);
      check($sformatf("rst_a%0d", d),    a_s[d],    0);
      check($sformatf("rst_b%0d", d),    b_s[d],    0);
      check($sformatf("rst_busy%0d", d), busy_s[d], 0);
      check($sformatf("rst_done%0d", d), done_s[d], 0);
      check($sformatf("rst_pass%0d", d), pass_s[d], 0);
      check($sformatf("rst_err%0d", d),  err_s[d],  0);
      check($sformatf("rst_fail%0d", d), fail_s[d], 0);
   endtask

   // One full run: start accepted at E0, then every cycle through done checked.
   task automatic run(input int d, input int unsigned sel, input logic [3:0] ftab,
                      input bit hold, input bit poke);
      int unsigned h;
      logic [3:0]  mm;
      h = hold_of(d);
      mm = ftab ^ model_tt(sel);
      @(negedge clk);
      sel_s[d]   = 3'(sel);
      ytab[d]    = ftab;
      start_s[d] = 1'b1;
      @(posedge clk);
      for (int c = 0; c < int'(4 * h); c++) begin
         int unsigned v;
         v = c / h;
         #1;
         check($sformatf("a%0d_c%0d", d, c), a_s[d], (v >> 1) & 1);
         check($sformatf("b%0d_c%0d", d, c), b_s[d], v & 1);
         check($sformatf("busy%0d_c%0d", d, c), busy_s[d], 1);
         check($sformatf("done%0d_c%0d", d, c), done_s[d], 0);
         @(negedge clk);
         if (!hold) start_s[d] = 1'b0;
         if (c == 1) begin
            sel_s[d] = 3'($urandom_range(0, 7));
            if (poke) start_s[d] = 1'b1;
         end
         @(posedge clk);
      end
      #1;
      check($sformatf("fin_done%0d", d), done_s[d], 1);
      check($sformatf("fin_busy%0d", d), busy_s[d], 0);
      check($sformatf("fin_ab%0d", d), {a_s[d], b_s[d]}, 0);
      check($sformatf("pass%0d_sel%0d", d, sel), pass_s[d], (mm == 4'd0) ? 1 : 0);
      check($sformatf("err%0d_sel%0d", d, sel), err_s[d], popcount4(mm));
      check($sformatf("fail%0d_sel%0d", d, sel), fail_s[d], mm);
      if (!hold) start_s[d] = 1'b0;
   endtask

   // One idle cycle after a run: done drops and results stay put.
   task automatic idle_check(input int d, input logic [3:0] mm);
      @(negedge clk);
      start_s[d] = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("idle_done%0d", d), done_s[d], 0);
      check($sformatf("idle_busy%0d", d), busy_s[d], 0);
      check($sformatf("hold_err%0d", d), err_s[d], popcount4(mm));
      check($sformatf("hold_fail%0d", d), fail_s[d], mm);
      check($sformatf("hold_pass%0d", d), pass_s[d], (mm == 4'd0) ? 1 : 0);
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0;
         sel_s[d]   = '0;
         ytab[d]    = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_reset_values(0);
      check_reset_values(1);
      @(negedge clk);
      rst = 1'b0;

      // Directed: AND good, AND stuck-0, NOR stuck-1, then a good XOR.
      run(0, 0, model_tt(0), 1'b0, 1'b0);
      idle_check(0, 4'b0000);
      run(0, 0, 4'b0000, 1'b0, 1'b0);
      idle_check(0, 4'b1000);
      run(0, 3, 4'b1111, 1'b0, 1'b0);
      idle_check(0, 4'b1110);
      run(0, 4, model_tt(4), 1'b0, 1'b1);
      idle_check(0, 4'b0000);

      // SETTLE 0, BUF with y=a, start held high across two runs.
      run(1, 7, 4'b1100, 1'b1, 1'b0);
      run(1, 7, 4'b1100, 1'b0, 1'b0);
      idle_check(1, 4'b0000);

      // Reset in the middle of a run (after edge E0+5).
      @(negedge clk);
      sel_s[0]   = 3'd2;
      ytab[0]    = 4'b0000;
      start_s[0] = 1'b1;
      @(posedge clk);
      #1;
      start_s[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mid_b_before_rst", b_s[0], 1);
      rst = 1'b1;
      #1;
      check_reset_values(0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk);
         #1;
         check("no_done_after_rst", done_s[0], 0);
      end
      run(0, 5, model_tt(5), 1'b0, 1'b0);

      // Randomized runs on both instances.
      for (int i = 0; i < 24; i++) begin
         int          d;
         int unsigned sel;
         int unsigned mode;
         logic [3:0]  ftab;
         d    = i % 2;
         sel  = $urandom_range(0, 7);
         mode = $urandom_range(0, 3);
         case (mode)
            0: ftab = model_tt(sel);
            1: ftab = 4'b0000;
            2: ftab = 4'b1111;
            default: ftab = 4'($urandom_range(0, 15));
         endcase
         run(d, sel, ftab, 1'b0, ($urandom_range(0, 1) == 1));
         if (i % 3 == 0) idle_check(d, ftab ^ model_tt(sel));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
